// File: rtl/trivium_decrypt.sv
// Bit-serial Trivium stream decryptor: key/IV load, warm-up, then one keystream bit per ciphertext bit.
// Optional delivered-bit counter enabled with `define TRIVIUM_DECRYPT_BITCOUNT_EN.
module trivium_decrypt #(
    parameter int unsigned WARMUP_CYCLES = 1152,
    parameter int unsigned CNT_W         = 32
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             start,
    input  logic [79:0]      key,
    input  logic [79:0]      iv,
    output logic             busy,
    input  logic             ct_valid,
    input  logic             ct_data,
    output logic             ct_ready,
    output logic             pt_valid,
    output logic             pt_data,
    input  logic             pt_ready,
    output logic [CNT_W-1:0] bit_count
);

    localparam int unsigned WcW = (WARMUP_CYCLES > 2) ? $clog2(WARMUP_CYCLES) : 1;
    localparam logic [WcW-1:0] WcLast = WcW'((WARMUP_CYCLES == 0) ? 0 : WARMUP_CYCLES - 1);

    typedef enum logic [1:0] {StIdle, StLoad, StWarm, StRun} state_e;

    state_e           st_q, st_d;
    logic [287:0]     s_q, s_d;
    logic [WcW-1:0]   wcnt_q, wcnt_d;
    logic             busy_q, busy_d;
    logic             pv_q, pv_d;
    logic             pd_q, pd_d;

    // s_q[i-1] holds cipher state bit s_i.
    logic         t1, t2, t3, t1n, t2n, t3n, z;
    logic [287:0] s_step;
    logic         accept;

    always_comb begin
        t1     = s_q[65] ^ s_q[92];
        t2     = s_q[161] ^ s_q[176];
        t3     = s_q[242] ^ s_q[287];
        z      = t1 ^ t2 ^ t3;
        t1n    = t1 ^ (s_q[90] & s_q[91]) ^ s_q[170];
        t2n    = t2 ^ (s_q[174] & s_q[175]) ^ s_q[263];
        t3n    = t3 ^ (s_q[285] & s_q[286]) ^ s_q[68];
        s_step = {s_q[286:177], t2n, s_q[175:93], t1n, s_q[91:0], t3n};
    end

    assign ct_ready = (st_q == StRun) && (!pv_q || pt_ready);
    assign accept   = ct_valid && ct_ready;

    always_comb begin
        st_d   = st_q;
        s_d    = s_q;
        wcnt_d = wcnt_q;
        busy_d = busy_q;
        pv_d   = pv_q;
        pd_d   = pd_q;
        if (start) begin
            // Key/IV are captured here; the LOAD cycle then already holds the loaded state.
            st_d   = StLoad;
            s_d    = {3'b111, 108'b0, 4'b0, iv, 13'b0, key};
            wcnt_d = '0;
            busy_d = 1'b1;
            pv_d   = 1'b0;
        end else begin
            unique case (st_q)
                StIdle: ;
                StLoad: begin
                    wcnt_d = '0;
                    if (WARMUP_CYCLES == 0) begin
                        st_d   = StRun;
                        busy_d = 1'b0;
                    end else begin
                        st_d = StWarm;
                    end
                end
                StWarm: begin
                    s_d = s_step;
                    if (wcnt_q == WcLast) begin
                        st_d   = StRun;
                        busy_d = 1'b0;
                    end else begin
                        wcnt_d = wcnt_q + WcW'(1);
                    end
                end
                StRun: begin
                    if (accept) begin
                        s_d  = s_step;
                        pd_d = ct_data ^ z;
                        pv_d = 1'b1;
                    end else if (pv_q && pt_ready) begin
                        pv_d = 1'b0;
                    end
                end
                default: st_d = StIdle;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            st_q   <= StIdle;
            s_q    <= '0;
            wcnt_q <= '0;
            busy_q <= 1'b0;
            pv_q   <= 1'b0;
            pd_q   <= 1'b0;
        end else begin
            st_q   <= st_d;
            s_q    <= s_d;
            wcnt_q <= wcnt_d;
            busy_q <= busy_d;
            pv_q   <= pv_d;
            pd_q   <= pd_d;
        end
    end

    assign busy     = busy_q;
    assign pt_valid = pv_q;
    assign pt_data  = pd_q;

`ifdef TRIVIUM_DECRYPT_BITCOUNT_EN
    logic [CNT_W-1:0] cnt_q, cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (start) begin
            cnt_d = '0;
        end else if (pv_q && pt_ready && (cnt_q != {CNT_W{1'b1}})) begin
            cnt_d = cnt_q + CNT_W'(1);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign bit_count = cnt_q;
`else
    assign bit_count = '0;
`endif

endmodule

// File: tb/tb_trivium_decrypt.sv
// Self-checking bench for trivium_decrypt: vector table for warm-up timing, round trip,
// backpressure, restart, reset abort and randomized traffic against a Trivium reference model.
module tb_trivium_decrypt;

    localparam int unsigned WARM   = 1152;
    localparam int unsigned CW     = 5;
    localparam int unsigned CntMax = (1 << CW) - 1;

    localparam logic [79:0] K1 = 80'h0123456789ABCDEF0123;
    localparam logic [79:0] I1 = 80'hFEDCBA9876543210FEDC;
    localparam logic [79:0] K2 = 80'h13579BDF02468ACE1357;
    localparam logic [79:0] I2 = 80'h0F1E2D3C4B5A69788796;
    localparam logic [63:0] PT = 64'hDEADBEEFCAFEF00D;

    logic          clk = 1'b0;
    logic          reset, start, ct_valid, ct_data, pt_ready;
    logic [79:0]   key, iv;
    logic          busy, ct_ready, pt_valid, pt_data;
    logic [CW-1:0] bit_count;

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    trivium_decrypt #(
        .WARMUP_CYCLES(WARM),
        .CNT_W        (CW)
    ) dut (
        .clk      (clk),
        .reset    (reset),
        .start    (start),
        .key      (key),
        .iv       (iv),
        .busy     (busy),
        .ct_valid (ct_valid),
        .ct_data  (ct_data),
        .ct_ready (ct_ready),
        .pt_valid (pt_valid),
        .pt_data  (pt_data),
        .pt_ready (pt_ready),
        .bit_count(bit_count)
    );

    // Reference cipher: st[i] is s_i, straight from the Trivium equations.
    function automatic bit [288:1] trv_load(input logic [79:0] k, input logic [79:0] v);
        bit [288:1] st = '0;
        st[80:1]    = k;
        st[173:94]  = v;
        st[288:286] = 3'b111;
        return st;
    endfunction

    function automatic bit trv_z(input bit [288:1] st);
        return st[66] ^ st[93] ^ st[162] ^ st[177] ^ st[243] ^ st[288];
    endfunction

    function automatic bit [288:1] trv_next(input bit [288:1] st);
        bit a, b, c;
        bit [288:1] n;
        a = st[66] ^ st[93] ^ (st[91] & st[92]) ^ st[171];
        b = st[162] ^ st[177] ^ (st[175] & st[176]) ^ st[264];
        c = st[243] ^ st[288] ^ (st[286] & st[287]) ^ st[69];
        n = st;
        n[93:1]    = {st[92:1], c};
        n[177:94]  = {st[176:94], a};
        n[288:178] = {st[287:178], b};
        return n;
    endfunction

    // First keystream bit lands in bit 63.
    function automatic logic [63:0] gold_ks(input logic [79:0] k, input logic [79:0] v);
        bit [288:1] st = trv_load(k, v);
        logic [63:0] r = '0;
        for (int i = 0; i < int'(WARM); i++) st = trv_next(st);
        for (int i = 0; i < 64; i++) begin
            r[63-i] = trv_z(st);
            st = trv_next(st);
        end
        return r;
    endfunction

    // Cycle-level behavioural model: 0 idle, 1 load, 2 warm-up, 3 run.
    int          m_phase = 0;
    int          m_wleft = 0;
    bit [288:1]  m_s     = '0;
    bit          m_pv    = 1'b0;
    bit          m_pd    = 1'b0;
    int unsigned m_cnt   = 0;

    function automatic logic [63:0] exp_count();
`ifdef TRIVIUM_DECRYPT_BITCOUNT_EN
        return 64'(m_cnt);
`else
        return 64'd0;
`endif
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic settle();
        bit rdy;
        #2;
        rdy = (m_phase == 3) && (!m_pv || pt_ready);
        chk("busy", 64'(busy), 64'(m_phase == 1 || m_phase == 2));
        chk("ct_ready", 64'(ct_ready), 64'(rdy));
        chk("pt_valid", 64'(pt_valid), 64'(m_pv));
        if (m_pv) chk("pt_data", 64'(pt_data), 64'(m_pd));
        chk("bit_count", 64'(bit_count), exp_count());
    endtask

    task automatic advance();
        bit rdy;
        if (reset) begin
            m_phase = 0; m_s = '0; m_pv = 0; m_pd = 0; m_cnt = 0;
        end else if (start) begin
            m_phase = 1; m_s = trv_load(key, iv); m_pv = 0; m_cnt = 0;
        end else begin
            rdy = (m_phase == 3) && (!m_pv || pt_ready);
            if (m_pv && pt_ready && m_cnt < CntMax) m_cnt++;
            case (m_phase)
                1: begin
                    if (WARM == 0) m_phase = 3;
                    else begin m_phase = 2; m_wleft = int'(WARM); end
                end
                2: begin
                    m_s = trv_next(m_s);
                    m_wleft--;
                    if (m_wleft == 0) m_phase = 3;
                end
                3: begin
                    if (ct_valid && rdy) begin
                        m_pd = ct_data ^ trv_z(m_s);
                        m_s  = trv_next(m_s);
                        m_pv = 1'b1;
                    end else if (m_pv && pt_ready) begin
                        m_pv = 1'b0;
                    end
                end
                default: ;
            endcase
        end
        @(posedge clk);
        @(negedge clk);
    endtask

    typedef struct {
        bit start;
        bit exp_busy;
        bit exp_rdy;
    } tvec_t;

    tvec_t       tv[$];
    tvec_t       t;
    logic [63:0] ks, got;
    int          nbits;
    logic        held;

    initial begin
        for (int c = 0; c <= int'(WARM) + 3; c++) begin
            t.start    = (c == 0);
            t.exp_busy = (c >= 1) && (c <= int'(WARM) + 1);
            t.exp_rdy  = (c >= int'(WARM) + 2);
            tv.push_back(t);
        end

        reset = 1; start = 1; ct_valid = 1; ct_data = 1; pt_ready = 1; key = K1; iv = I1;
        @(negedge clk);
        // Reset overrides start and ct_valid.
        for (int i = 0; i < 3; i++) begin
            advance();
            settle();
            chk("rst_busy", 64'(busy), 64'd0);
            chk("rst_ct_ready", 64'(ct_ready), 64'd0);
            chk("rst_pt_valid", 64'(pt_valid), 64'd0);
            chk("rst_pt_data", 64'(pt_data), 64'd0);
        end
        reset = 0; start = 0;
        for (int i = 0; i < 3; i++) begin
            settle();
            advance();
        end
        chk("idle_ct_ready", 64'(ct_ready), 64'd0);

        // Warm-up timing table, cycle 0 carries the start pulse.
        ct_valid = 0;
        foreach (tv[i]) begin
            start = tv[i].start;
            settle();
            chk("tbl_busy", 64'(busy), 64'(tv[i].exp_busy));
            chk("tbl_ct_ready", 64'(ct_ready), 64'(tv[i].exp_rdy));
            advance();
        end
        start = 0;

        // Round trip at full throughput.
        ks = gold_ks(K1, I1);
        got = '0; nbits = 0;
        for (int i = 0; i <= 64; i++) begin
            ct_valid = (i < 64);
            ct_data  = (i < 64) ? (PT[63-i] ^ ks[63-i]) : 1'b0;
            settle();
            if (pt_valid && pt_ready) begin
                got = {got[62:0], pt_data};
                nbits++;
            end
            advance();
        end
        ct_valid = 0;
        settle();
        chk("roundtrip", got, PT);
        chk("rt_nbits", 64'(nbits), 64'd64);
`ifdef TRIVIUM_DECRYPT_BITCOUNT_EN
        chk("bitcount_sat", 64'(bit_count), 64'(CntMax));
`else
        chk("bitcount_tied", 64'(bit_count), 64'd0);
`endif
        advance();

        // Backpressure: one bit parked, no acceptance for 10 cycles.
        ct_valid = 1; ct_data = 1; pt_ready = 0;
        settle();
        advance();
        settle();
        held = pt_data;
        for (int i = 0; i < 10; i++) begin
            ct_data = 1'($urandom);
            settle();
            chk("bp_valid", 64'(pt_valid), 64'd1);
            chk("bp_stable", 64'(pt_data), 64'(held));
            chk("bp_ct_ready", 64'(ct_ready), 64'd0);
            advance();
        end

        // Randomized traffic.
        for (int i = 0; i < 800; i++) begin
            ct_valid = ($urandom % 4) != 0;
            ct_data  = 1'($urandom);
            pt_ready = ($urandom % 3) != 0;
            settle();
            advance();
        end

        // Restart from RUN with a bit pending.
        ct_valid = 1; pt_ready = 0;
        settle();
        advance();
        settle();
        chk("rs_pending", 64'(pt_valid), 64'd1);
        start = 1; key = K2; iv = I2; ct_valid = 0;
        advance();
        start = 0;
        settle();
        chk("rs_pt_valid", 64'(pt_valid), 64'd0);
        chk("rs_busy", 64'(busy), 64'd1);
        for (int i = 0; i < int'(WARM) + 4 && m_phase != 3; i++) begin
            settle();
            advance();
        end
        chk("rs_reached_run", 64'(m_phase), 64'd3);
        ks = gold_ks(K2, I2);
        got = '0; nbits = 0; pt_ready = 1;
        for (int i = 0; i <= 16; i++) begin
            ct_valid = (i < 16);
            ct_data  = 1'b0;
            settle();
            if (pt_valid && pt_ready) begin
                got = {got[62:0], pt_data};
                nbits++;
            end
            advance();
        end
        chk("rs_keystream", got[15:0], ks[63:48]);
        chk("rs_nbits", 64'(nbits), 64'd16);

        // Reset mid-stream aborts; nothing comes out afterwards.
        ct_valid = 1; pt_ready = 0;
        settle();
        advance();
        reset = 1;
        settle();
        advance();
        reset = 0; pt_ready = 1;
        for (int i = 0; i < 6; i++) begin
            settle();
            chk("abort_pt_valid", 64'(pt_valid), 64'd0);
            chk("abort_ct_ready", 64'(ct_ready), 64'd0);
            advance();
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/trivium_decrypt.md
Name: trivium_decrypt

Overview:
Bit-serial Trivium-style stream decryptor. It is the receive-side counterpart of the keystream encryptor.
- Loads an 80-bit key and an 80-bit IV into a 288-bit state, runs the warm-up rounds, then XORs each incoming ciphertext bit with one keystream bit to recover plaintext.
- Sits between the link deserializer (ciphertext source) and the plaintext consumer.
- Valid/ready handshake on both sides.

Parameters:
- WARMUP_CYCLES, 1152, number of state updates after load before the first keystream bit is used (4*288 per Trivium; benches reduce it).
- CNT_W, 32, width of the optional delivered-bit counter.

Ports:
- clk  input  1  clock; all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- start  input  1  single-cycle pulse; samples key/iv and begins load.
- key  input  80  cipher key; key[0] maps to s1.
- iv  input  80  initialisation vector; iv[0] maps to s94.
- busy  output  1  high during LOAD and WARMUP.
- ct_valid  input  1  ciphertext bit valid.
- ct_data  input  1  ciphertext bit.
- ct_ready  output  1  decryptor accepts ciphertext this cycle.
- pt_valid  output  1  plaintext bit valid.
- pt_data  output  1  plaintext bit.
- pt_ready  input  1  consumer accepts plaintext.
- bit_count  output  CNT_W  plaintext bits delivered (see Optional Feature).

Behaviour:
- reset=1 at a clock edge:
  - state=IDLE, 288-bit state register cleared, warm-up counter=0.
  - busy=0, ct_ready=0, pt_valid=0, pt_data=0, bit_count=0.
  - Overrides start in the same cycle. Reset mid-operation aborts everything; no output is produced afterwards until a new start.
- States: IDLE -> LOAD -> WARMUP -> RUN.
  - IDLE: wait for start.
  - start (any state, reset low) -> LOAD next cycle. Restart from WARMUP or RUN clears pt_valid and discards any pending plaintext bit.
  - LOAD (1 cycle) writes:
    - s1..s80 = key, s81..s93 = 0
    - s94..s173 = iv, s174..s177 = 0
    - s178..s285 = 0, s286..s288 = 1
  - WARMUP: one state update per cycle for exactly WARMUP_CYCLES cycles, then RUN. With WARMUP_CYCLES=0, LOAD goes directly to RUN.
  - RUN: stays until start or reset.
- State update (one step):
  - t1 = s66^s93, t2 = s162^s177, t3 = s243^s288
  - z = t1^t2^t3
  - t1' = t1^(s91&s92)^s171
  - t2' = t2^(s175&s176)^s264
  - t3' = t3^(s286&s287)^s69
  - Shift: s1..s93 <- {t3', s1..s92}; s94..s177 <- {t1', s94..s176}; s178..s288 <- {t2', s178..s287}.
- ct_ready = (state==RUN) && (!pt_valid || pt_ready). Combinational; ct_ready does not depend on ct_valid.
- Accept = ct_valid && ct_ready. On accept:
  - pt_data <= ct_data ^ z, pt_valid <= 1.
  - The cipher state steps exactly once.
  - No accept means no step; the keystream never advances in RUN without data.
- pt_valid && pt_ready without a new accept -> pt_valid <= 0. Simultaneous drain and accept keeps pt_valid=1 with the new bit, giving full throughput of 1 bit/cycle.
- pt_data and pt_valid stay stable while pt_valid && !pt_ready.
- Latency: ciphertext accepted at edge N -> plaintext visible after edge N.
- busy is registered: 1 in the cycle after start, through the last WARMUP cycle.

Optional Feature:
- Macro: TRIVIUM_DECRYPT_BITCOUNT_EN.
- Defined:
  - bit_count increments by 1 on every pt_valid && pt_ready.
  - Saturates at all-ones (no wrap).
  - Cleared by reset and by start.
- Undefined: bit_count is tied to 0 and the counter logic is absent.

Test Plan:
- Reset: hold reset=1 for 3 cycles with start=1, ct_valid=1 -> busy=0, ct_ready=0, pt_valid=0, bit_count=0; state stays IDLE.
- Warm-up timing: WARMUP_CYCLES=4, start at cycle 0 -> busy=1 on cycles 1..5, ct_ready=1 first at cycle 6 with pt_ready=1.
- Round trip: key=80'h0123456789ABCDEF0123, iv=80'hFEDCBA9876543210FEDC, WARMUP_CYCLES=1152. Feed 64 ciphertext bits produced by the golden model from plaintext 64'hDEADBEEFCAFEF00D -> output bits equal 64'hDEADBEEFCAFEF00D in order; bit_count=64 when the feature is enabled.
- Backpressure: hold pt_ready=0 for 10 cycles mid-stream -> one bit held stable, ct_ready=0, no keystream step. Releasing resumes with no lost or duplicated bits versus the model.
- Restart: pulse start during RUN with pt_valid=1 -> pt_valid=0 next cycle, busy=1. After warm-up the keystream restarts from the first bit for the new key/iv.
- Counter saturation (TRIVIUM_DECRYPT_BITCOUNT_EN, CNT_W=3): deliver 10 bits -> bit_count reads 7 and holds.
